// File: rtl/enc_16x4_queue.sv
// enc_16x4_queue: sequential 16-to-4 encoder.
// Request strobes are collected in a sticky pending register and issued one
// index at a time through a valid/ready output register. RR selects fixed
// priority (highest index first, RR=0) or round-robin from last issued + 1 (RR=1).
module enc_16x4_queue #(
    parameter int unsigned RR = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        clr,
    output logic [3:0]  code,
    output logic        valid,
    input  logic        ready,
    output logic [15:0] pending,
    output logic        overflow
);

    logic [15:0] pending_q, pending_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        overflow_q, overflow_d;
    logic [3:0]  last_q, last_d;

    logic [3:0]  sel;
    logic        any;
    logic        load;
    logic [15:0] pop_mask;

    // Pick the next index to issue from the registered pending bits.
    always_comb begin
        sel = '0;
        any = |pending_q;
        if (RR == 0) begin
            // Ascending scan: the last hit is the highest set index.
            for (int unsigned i = 0; i < 16; i++) begin
                if (pending_q[i]) sel = 4'(i);
            end
        end else begin
            // Descending offset scan: the last hit is the closest index after last_q.
            for (int unsigned k = 16; k >= 1; k--) begin
                if (pending_q[last_q + 4'(k)]) sel = last_q + 4'(k);
            end
        end
    end

    // Next-state for the pending register, output stage and round-robin pointer.
    always_comb begin
        load       = !valid_q || ready;
        pop_mask   = (load && any) ? (16'd1 << sel) : '0;
        pending_d  = (pending_q & ~pop_mask) | req;
        overflow_d = |(req & pending_q & ~pop_mask);
        code_d     = code_q;
        valid_d    = valid_q;
        last_d     = last_q;
        if (load) begin
            if (any) begin
                code_d  = sel;
                valid_d = 1'b1;
                if (RR != 0) last_d = sel;
            end else begin
                valid_d = 1'b0;
            end
        end
        if (clr) begin
            pending_d  = '0;
            code_d     = '0;
            valid_d    = 1'b0;
            overflow_d = 1'b0;
            last_d     = last_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q  <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            last_q     <= 4'hF;
        end else begin
            pending_q  <= pending_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
        end
    end

    assign code     = code_q;
    assign valid    = valid_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_enc_16x4_queue.sv
// Directed bench for enc_16x4_queue: one fixed-priority and one round-robin
// instance share the same stimulus; each table row is checked after its edge.
module tb_enc_16x4_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] req = '0;
    logic        ready = 1'b0;

    logic [3:0]  code0, code1;
    logic        valid0, valid1;
    logic [15:0] pending0, pending1;
    logic        overflow0, overflow1;

    int total = 0;
    int bad = 0;

    enc_16x4_queue #(.RR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .clr(clr),
        .code(code0), .valid(valid0), .ready(ready),
        .pending(pending0), .overflow(overflow0)
    );

    enc_16x4_queue #(.RR(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .clr(clr),
        .code(code1), .valid(valid1), .ready(ready),
        .pending(pending1), .overflow(overflow1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        clr;
        logic [15:0] req;
        logic        ready;
        logic [3:0]  code;
        logic        valid;
        logic [15:0] pending;
        logic        overflow;
    } vec_t;

    vec_t tab0[$];
    vec_t tab1[$];

    function automatic vec_t mk(logic rn, logic c, logic [15:0] r, logic rd,
                                logic [3:0] ec, logic ev, logic [15:0] ep, logic eo);
        vec_t v;
        v.rst_n = rn; v.clr = c; v.req = r; v.ready = rd;
        v.code = ec; v.valid = ev; v.pending = ep; v.overflow = eo;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    // Drive one row, clock it, then compare the selected instance's outputs.
    task automatic apply(input vec_t v, input int which, input int row);
        rst_n = v.rst_n; clr = v.clr; req = v.req; ready = v.ready;
        @(posedge clk);
        #1;
        if (which == 0) begin
            chk("rr0_code", row, {12'd0, code0}, {12'd0, v.code});
            chk("rr0_valid", row, {15'd0, valid0}, {15'd0, v.valid});
            chk("rr0_pending", row, pending0, v.pending);
            chk("rr0_overflow", row, {15'd0, overflow0}, {15'd0, v.overflow});
        end else begin
            chk("rr1_code", row, {12'd0, code1}, {12'd0, v.code});
            chk("rr1_valid", row, {15'd0, valid1}, {15'd0, v.valid});
            chk("rr1_pending", row, pending1, v.pending);
            chk("rr1_overflow", row, {15'd0, overflow1}, {15'd0, v.overflow});
        end
    endtask

    initial begin
        // Fixed priority:     rst  clr  req       rdy  code   vld  pending   ovf
        tab0.push_back(mk(0, 0, 16'hFFFF, 1, 4'd0,  0, 16'h0000, 0)); // reset ignores req
        tab0.push_back(mk(1, 0, 16'h0001, 1, 4'd0,  0, 16'h0001, 0));
        tab0.push_back(mk(1, 0, 16'h0000, 1, 4'd0,  1, 16'h0000, 0)); // 2 cycles to valid
        tab0.push_back(mk(1, 0, 16'h0000, 1, 4'd0,  0, 16'h0000, 0));
        tab0.push_back(mk(1, 0, 16'h8421, 1, 4'd0,  0, 16'h8421, 0));
        tab0.push_back(mk(1, 0, 16'h0000, 1, 4'd15, 1, 16'h0421, 0));
        tab0.push_back(mk(1, 0, 16'h0000, 1, 4'd10, 1, 16'h0021, 0));
        tab0.push_back(mk(1, 0, 16'h0000, 1, 4'd5,  1, 16'h0001, 0));
        tab0.push_back(mk(1, 0, 16'h0000, 1, 4'd0,  1, 16'h0000, 0));
        tab0.push_back(mk(1, 0, 16'h0000, 1, 4'd0,  0, 16'h0000, 0));
        tab0.push_back(mk(1, 0, 16'h0008, 0, 4'd0,  0, 16'h0008, 0)); // back-pressure
        tab0.push_back(mk(1, 0, 16'h0000, 0, 4'd3,  1, 16'h0000, 0));
        tab0.push_back(mk(1, 0, 16'h0010, 0, 4'd3,  1, 16'h0010, 0));
        tab0.push_back(mk(1, 0, 16'h0000, 0, 4'd3,  1, 16'h0010, 0));
        tab0.push_back(mk(1, 0, 16'h0010, 0, 4'd3,  1, 16'h0010, 1)); // duplicate
        tab0.push_back(mk(1, 0, 16'h0000, 0, 4'd3,  1, 16'h0010, 0));
        tab0.push_back(mk(1, 0, 16'h0000, 1, 4'd4,  1, 16'h0000, 0));
        tab0.push_back(mk(1, 0, 16'h0000, 1, 4'd4,  0, 16'h0000, 0));
        tab0.push_back(mk(1, 0, 16'h0001, 1, 4'd4,  0, 16'h0001, 0)); // pop + re-request
        tab0.push_back(mk(1, 0, 16'h0001, 1, 4'd0,  1, 16'h0001, 0));
        tab0.push_back(mk(1, 0, 16'h0000, 1, 4'd0,  1, 16'h0000, 0));
        tab0.push_back(mk(1, 0, 16'h0000, 1, 4'd0,  0, 16'h0000, 0));
        tab0.push_back(mk(1, 0, 16'h0006, 1, 4'd0,  0, 16'h0006, 0)); // multi-hit
        tab0.push_back(mk(1, 0, 16'h0006, 0, 4'd2,  1, 16'h0006, 1));
        tab0.push_back(mk(1, 0, 16'h0000, 0, 4'd2,  1, 16'h0006, 0));
        tab0.push_back(mk(1, 0, 16'hFFFF, 0, 4'd2,  1, 16'hFFFF, 1)); // flush
        tab0.push_back(mk(1, 1, 16'h0002, 0, 4'd0,  0, 16'h0000, 0));
        tab0.push_back(mk(1, 0, 16'hFFFF, 0, 4'd0,  0, 16'hFFFF, 0));
        tab0.push_back(mk(1, 0, 16'h0000, 0, 4'd15, 1, 16'h7FFF, 0));
        tab0.push_back(mk(0, 0, 16'h0002, 0, 4'd0,  0, 16'h0000, 0));
        tab0.push_back(mk(1, 0, 16'h0000, 1, 4'd0,  0, 16'h0000, 0));

        // Round-robin:        rst  clr  req       rdy  code   vld  pending   ovf
        tab1.push_back(mk(0, 0, 16'h0000, 1, 4'd0,  0, 16'h0000, 0));
        tab1.push_back(mk(1, 0, 16'h8421, 1, 4'd0,  0, 16'h8421, 0));
        tab1.push_back(mk(1, 0, 16'h0000, 1, 4'd0,  1, 16'h8420, 0));
        tab1.push_back(mk(1, 0, 16'h0000, 1, 4'd5,  1, 16'h8400, 0));
        tab1.push_back(mk(1, 0, 16'h0000, 1, 4'd10, 1, 16'h8000, 0)); // last=10
        tab1.push_back(mk(1, 0, 16'h0401, 1, 4'd15, 1, 16'h0401, 0));
        tab1.push_back(mk(1, 0, 16'h0000, 1, 4'd0,  1, 16'h0400, 0)); // wrap
        tab1.push_back(mk(1, 0, 16'h0000, 1, 4'd10, 1, 16'h0000, 0));
        tab1.push_back(mk(1, 0, 16'h0000, 1, 4'd10, 0, 16'h0000, 0));
        tab1.push_back(mk(1, 1, 16'h0000, 1, 4'd0,  0, 16'h0000, 0)); // clr keeps last
        tab1.push_back(mk(1, 0, 16'h0801, 1, 4'd0,  0, 16'h0801, 0));
        tab1.push_back(mk(1, 0, 16'h0000, 1, 4'd11, 1, 16'h0001, 0));
        tab1.push_back(mk(1, 0, 16'h0000, 1, 4'd0,  1, 16'h0000, 0));
        tab1.push_back(mk(1, 0, 16'h0000, 1, 4'd0,  0, 16'h0000, 0));
        tab1.push_back(mk(0, 0, 16'h0000, 1, 4'd0,  0, 16'h0000, 0)); // reset: last=15
        tab1.push_back(mk(1, 0, 16'h0801, 1, 4'd0,  0, 16'h0801, 0));
        tab1.push_back(mk(1, 0, 16'h0000, 1, 4'd0,  1, 16'h0800, 0));
        tab1.push_back(mk(1, 0, 16'h0000, 1, 4'd11, 1, 16'h0000, 0));
        tab1.push_back(mk(1, 0, 16'h0000, 1, 4'd11, 0, 16'h0000, 0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tab0.size(); i++) apply(tab0[i], 0, i);
        for (int i = 0; i < tab1.size(); i++) apply(tab1[i], 1, i);

        // Full drain: both instances issue all 16 codes back to back.
        rst_n = 1'b0; clr = 1'b0; req = '0; ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; req = 16'hFFFF;
        @(posedge clk); #1;
        req = '0;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            chk("drain_rr0_code", n, {12'd0, code0}, 16'(15 - n));
            chk("drain_rr0_valid", n, {15'd0, valid0}, 16'd1);
            chk("drain_rr1_code", n, {12'd0, code1}, 16'(n));
            chk("drain_rr1_valid", n, {15'd0, valid1}, 16'd1);
        end
        @(posedge clk); #1;
        chk("drain_rr0_end", 16, {15'd0, valid0}, 16'd0);
        chk("drain_rr1_end", 16, {15'd0, valid1}, 16'd0);
        chk("drain_rr0_pend", 16, pending0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enc_16x4_queue.md
Name: enc_16x4_queue

Overview:
- Sequential 16-to-4 encoder: inverse direction of the 4-to-16 decoders in this design.
- Captures request pulses on 16 one-hot/multi-hot lines into a sticky pending register.
- Issues each pending request as a 4-bit index code through a valid/ready output register, one code per handshake.
- Sits between event sources (decoder outputs, interrupt-style strobes) and a consumer that accepts one encoded index at a time.

Parameters:
- RR, default 0: arbitration mode. 0 = fixed priority, highest index wins. 1 = round-robin, search starts at last issued index + 1 and wraps 15->0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req  input  16  request lines; req[i] high for a cycle sets pending bit i.
- clr  input  1  synchronous flush of pending and output stage.
- code  output  4  encoded index of issued request; meaningful only when valid=1.
- valid  output  1  code holds an issued request.
- ready  input  1  consumer accepts code when valid&ready.
- pending  output  16  current pending register (requests not yet issued).
- overflow  output  1  one-cycle pulse: a request hit an already-pending bit.

Behaviour:
- Reset (rst_n=0 at a clock edge) forces:
  - pending=0, code=0, valid=0, overflow=0.
  - RR pointer last=15, so the first round-robin search starts at index 0.
  - req is ignored that cycle.
  - Reset mid-transfer drops the in-flight code and all pending requests; no handshake completes that cycle.
- clr=1 (rst_n=1) has the same effect as reset except that last is unchanged. req in the same cycle is discarded.
- Load condition: load = !valid || ready. The output register is empty or being consumed.
- Selection sel is computed combinationally from the registered pending value:
  - RR=0: highest set index.
  - RR=1: first set index scanning last+1, last+2, ... mod 16.
  - any = |pending.
- On an edge with load=1:
  - If any=1: code<=sel, valid<=1, pending bit sel cleared, and last<=sel when RR=1.
  - If any=0: valid<=0 and code holds its previous value.
- On an edge with load=0: code and valid hold, and pending bits are only added to.
- Pending update: pending_next = (pending & ~pop_mask) | req.
  - pop_mask = onehot(sel) when load&any, else 0.
  - If req[i] coincides with popping bit i, the bit stays set and is issued again later. This is not an overflow.
- overflow_next = |(req & pending & ~pop_mask). It is registered and high for exactly one cycle per offending cycle. Multiple coincident hits produce a single pulse.
- Latency, idle block: req[i] at edge t sets pending[i] visible after t. code=i, valid=1 after edge t+1, i.e. 2 cycles from request to valid.
- Throughput: one code per cycle while ready=1 and pending≠0.
- Back-pressure: with valid=1 and ready=0, code/valid are stable; pending accumulates. Duplicate requests merge and raise overflow.
- Code width: bit i ↔ code i, unsigned 4-bit. Index 15 ↔ 4'b1111.
- No combinational path from req or ready to code/valid/overflow. pending is a register output.

Test Plan:
- Reset then req=16'h0001 for 1 cycle, ready=1 -> pending=0001 after 1 edge; code=0, valid=1 after 2nd edge; valid=0 on the next edge.
- RR=0, req=16'h8421 in one cycle, ready=1 -> codes 15, 10, 5, 0 on consecutive cycles, then valid=0, pending=0.
- RR=1, req=16'h8421 issued so that last=10, then req=16'h0401 -> next issued codes 15, 0, 10 (wrap order), then valid=0.
- ready=0 while valid=1 with code=3, req=16'h0010 twice on separate cycles -> code stays 3; pending=0010; one overflow pulse on the second request. Raise ready -> codes 3 then 4.
- Back-to-back with ready=1: pending=0001 and req=16'h0001 in the cycle bit 0 is popped -> code=0 issued, pending[0] stays 1, overflow=0, code=0 issued again next cycle.
- pending=16'hFFFF, valid=1, assert clr with req=16'h0002 -> next edge pending=0, valid=0, overflow=0. Repeat with rst_n=0 -> code=0, RR restart at index 0.
